// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and multiply/divide stalls plus a precise-interrupt FSM.
// Optional HI/LO busy stall is compiled in with the HAZARD_MD_STALL_EN macro.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_md_use,
    input  logic              ex_md_start,
    input  logic              ex_md_div,
    input  logic              id_is_cti,
    input  logic              id_eret,
    input  logic              int_req,
    output logic              pc_write,
    output logic              id_flush,
    output logic              if_flush,
    output logic              exl_set,
    output logic              exl_clr,
    output logic              md_busy,
    output logic              int_pending,
    output logic [1:0]        int_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACCEPT = 2'd2,
        SERV   = 2'd3
    } int_state_t;

    int_state_t state_q, state_d;
    logic       load_use;
    logic       md_stall;
    logic       stall;

    // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_load && (ex_rd != '0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

`ifdef HAZARD_MD_STALL_EN
    localparam logic [7:0] MUL_LD = 8'(MUL_CYCLES);
    localparam logic [7:0] DIV_LD = 8'(DIV_CYCLES);

    logic [7:0] md_cnt;

    // A start arriving while the unit is busy is dropped, not queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= 8'd0;
        end else if (md_cnt != 8'd0) begin
            md_cnt <= md_cnt - 8'd1;
        end else if (ex_md_start) begin
            md_cnt <= ex_md_div ? DIV_LD : MUL_LD;
        end
    end

    assign md_busy  = (md_cnt != 8'd0);
    assign md_stall = md_busy && id_md_use;
`else
    logic md_unused;
    assign md_unused = ^{ex_md_start, ex_md_div, id_md_use};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

    assign stall    = load_use || md_stall;
    assign pc_write = !stall;
    assign id_flush = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Interrupts are taken only on a clean boundary: no branch/jump in ID and no stall.
    always_comb begin
        state_d     = state_q;
        exl_set     = 1'b0;
        if_flush    = 1'b0;
        exl_clr     = 1'b0;
        int_pending = 1'b0;
        case (state_q)
            IDLE: begin
                if (int_req) state_d = PEND;
            end
            PEND: begin
                int_pending = 1'b1;
                if (!id_is_cti && !stall) state_d = ACCEPT;
            end
            ACCEPT: begin
                exl_set  = 1'b1;
                if_flush = 1'b1;
                state_d  = SERV;
            end
            SERV: begin
                if (id_eret && !stall) begin
                    exl_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign int_state = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, multiply busy cycles (1..255).
REQ-003 SHALL have parameter DIV_CYCLES, default 32, divide busy cycles (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports id_rs, id_rt  input  REG_AW  source registers of the instruction in ID.
REQ-007 SHALL have ports id_use_rs, id_use_rt  input  1  ID instruction reads rs or rt.
REQ-008 SHALL have ports ex_load  input  1, ex_rd  input  REG_AW  EX holds a load writing ex_rd.
REQ-009 SHALL have ports id_md_use  input  1  ID instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
REQ-010 SHALL have ports ex_md_start  input  1, ex_md_div  input  1  EX starts a multiply (0) or divide (1).
REQ-011 SHALL have ports id_is_cti  input  1, id_eret  input  1, int_req  input  1.
REQ-012 SHALL have outputs pc_write, id_flush, if_flush, exl_set, exl_clr, md_busy, int_pending  1 bit each.

Function
REQ-013 SHALL compute load_use = ex_load & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)), combinational.
REQ-014 SHALL hold an 8-bit md_cnt; md_busy = (md_cnt!=0).
REQ-015 SHALL load md_cnt with DIV_CYCLES or MUL_CYCLES when ex_md_start=1 and md_cnt==0; ex_md_start while md_busy is ignored.
REQ-016 SHALL decrement a nonzero md_cnt by 1 each cycle, never wrapping below 0.
REQ-017 SHALL compute md_stall = md_busy & id_md_use; stall = load_use | md_stall; simultaneous causes yield one stall.
REQ-018 SHALL drive pc_write = !stall and id_flush = stall, combinational, zero latency.
REQ-019 SHALL implement interrupt FSM states IDLE, PEND, ACCEPT, SERV.
REQ-020 IDLE -> PEND when int_req=1; int_pending=1 in PEND.
REQ-021 PEND latches the request: int_req deasserting in PEND does not leave PEND.
REQ-022 PEND -> ACCEPT only in a cycle with id_is_cti=0 and stall=0; otherwise stays in PEND.
REQ-023 ACCEPT lasts exactly one cycle with exl_set=1 and if_flush=1, then -> SERV.
REQ-024 SERV ignores int_req; exl_clr = id_eret & stall=0 in SERV; that cycle -> IDLE.
REQ-025 id_eret outside SERV SHALL be ignored (exl_clr=0, no transition).
REQ-026 exl_set, if_flush, exl_clr SHALL be 0 in all states other than those stated.

Reset
REQ-027 reset=1 SHALL clear md_cnt to 0 and force FSM to IDLE on the next edge, including mid-divide or in PEND/SERV.
REQ-028 During and after reset with all inputs 0: pc_write=1; id_flush, if_flush, exl_set, exl_clr, md_busy, int_pending = 0.
REQ-029 A request present during reset SHALL be sampled only on the first edge after reset deasserts.

Configuration
REQ-030 With HAZARD_MD_STALL_EN defined, md_cnt, md_busy and md_stall SHALL behave per REQ-014..017.
REQ-031 Without HAZARD_MD_STALL_EN, md_cnt SHALL be absent, md_busy=0, md_stall=0, ex_md_start/ex_md_div/id_md_use ignored; stall = load_use.

Verification
REQ-032 ex_load=1, ex_rd=8, id_rs=8, id_use_rs=1 -> pc_write=0, id_flush=1 same cycle; ex_rd=0 instead -> no stall.
REQ-033 (MD_EN) ex_md_start=1, ex_md_div=1 for one cycle -> md_busy=1 for exactly 32 cycles; id_md_use=1 throughout -> pc_write=0 those 32 cycles, 1 on the 33rd.
REQ-034 int_req pulse 1 cycle while id_is_cti=1 for 3 cycles -> int_pending=1 for 4 cycles, exl_set=if_flush=1 one cycle after id_is_cti drops.
REQ-035 In SERV: int_req=1 -> no exl_set; id_eret=1 with stall=0 -> exl_clr=1 one cycle, FSM IDLE; id_eret in IDLE -> exl_clr=0.
REQ-036 reset=1 at md_cnt=10 while in PEND -> next cycle md_busy=0, int_pending=0, pc_write=1.
REQ-037 (MD_EN off) ex_md_start=1, id_md_use=1 -> md_busy=0, pc_write=1.
